// File: rtl/store_data_aligner_pkg.sv
// rtl/store_data_aligner_pkg.sv - shared encodings and entry sizing for the store path
package store_data_aligner_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } head_state_t;

  // Buffer entry layout: {word address, lane-replicated data, byte enables}
  function automatic int entry_width(input int aw);
    return aw + 32 + 4;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - narrows store data onto byte lanes and flags misalignment
module store_lane_align
  import store_data_aligner_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misalign
);

  always_comb begin
    wdata    = data;
    be       = 4'b0000;
    misalign = 1'b0;
    case (size)
      SZ_B: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      SZ_H: begin
        wdata    = {2{data[15:0]}};
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      SZ_W: begin
        be       = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_data_aligner.sv
// rtl/store_data_aligner.sv - aligns stores, buffers them and issues to data memory over req/ack
module store_data_aligner
  import store_data_aligner_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [1:0]    st_size,
  output logic          st_misalign,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  output logic          buf_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = entry_width(AW);

  logic [31:0]   al_wdata;
  logic [3:0]    al_be;
  logic          al_misalign;
  logic          push, pop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] fifo [DEPTH];
  logic [EW-1:0] head;
  head_state_t   state, state_nxt;

  store_lane_align u_align (
    .addr_lo  (st_addr[1:0]),
    .data     (st_data),
    .size     (st_size),
    .wdata    (al_wdata),
    .be       (al_be),
    .misalign (al_misalign)
  );

  // Readiness comes only from the registered count, so a pop never frees a slot in the same cycle
  assign st_ready    = (count < CW'(DEPTH));
  assign st_misalign = st_valid && al_misalign;
  assign push        = st_valid && st_ready && !al_misalign;
  assign pop         = mem_req && mem_ack;
  assign buf_empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= {st_addr[AW-1:2], 2'b00, al_wdata, al_be};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (push) state_nxt = ST_REQ;
      ST_REQ:  if (pop && !push && count == CW'(1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Head fields are masked while idle so the memory bus reads zero out of reset
  always_comb begin
    mem_req   = (state == ST_REQ);
    head      = fifo[rd_ptr];
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (mem_req) begin
      mem_addr  = head[EW-1 -: AW];
      mem_wdata = head[35:4];
      mem_be    = head[3:0];
    end
  end

endmodule
